// File: rtl/pwm_display_sequencer_pkg.sv
// rtl/pwm_display_sequencer_pkg.sv - shared state encoding and select constants
package pwm_display_sequencer_pkg;

  typedef enum logic [1:0] {
    S_SHOW_F = 2'd0,
    S_SHOW_C = 2'd1,
    S_HOLD_F = 2'd2,
    S_HOLD_C = 2'd3
  } state_t;

  localparam logic SEL_FREQ = 1'b0;
  localparam logic SEL_CURR = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_display_sequencer_btn_debounce.sv
// rtl/pwm_display_sequencer_btn_debounce.sv - button synchronizer, debounce and press pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      // Any return to the stable level restarts the qualification window.
      if (sync2 != stable) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          stable <= sync2;
          cnt    <= '0;
          press  <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_display_sequencer.sv
// rtl/pwm_display_sequencer.sv - front-panel indicator counters and display-mux sequencer
module pwm_display_sequencer
  import pwm_display_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES   = 500000,
  parameter int DWELL_CYCLES = 100000000,
  parameter int HOLD_CYCLES  = 150000000,
  parameter int F_MAX        = 5,
  parameter int C_MAX        = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_f_up,
  input  logic       btn_f_dn,
  input  logic       btn_c_up,
  input  logic       btn_c_dn,
  input  logic       auto_en,
  input  logic       sel_manual,
  output logic [2:0] iF,
  output logic [3:0] iC,
  output logic       switch
);

  localparam int CW = $clog2(max_int(DWELL_CYCLES, HOLD_CYCLES));
  localparam logic [2:0] F_TOP = 3'(F_MAX);
  localparam logic [3:0] C_TOP = 4'(C_MAX);

  logic f_up, f_dn, c_up, c_dn;
  logic f_adj, c_adj;
  state_t state;
  logic [CW-1:0] cnt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_f_up (.clock(clock), .reset(reset), .btn(btn_f_up), .press(f_up));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_f_dn (.clock(clock), .reset(reset), .btn(btn_f_dn), .press(f_dn));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_c_up (.clock(clock), .reset(reset), .btn(btn_c_up), .press(c_up));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_c_dn (.clock(clock), .reset(reset), .btn(btn_c_dn), .press(c_dn));

  // A saturated or cancelled press is still an adjust for the scheduler.
  assign f_adj = f_up | f_dn;
  assign c_adj = c_up | c_dn;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iF <= 3'd0;
      iC <= 4'd0;
    end else begin
      if (f_up && !f_dn && iF != F_TOP)
        iF <= iF + 3'd1;
      else if (f_dn && !f_up && iF != 3'd0)
        iF <= iF - 3'd1;
      if (c_up && !c_dn && iC != C_TOP)
        iC <= iC + 4'd1;
      else if (c_dn && !c_up && iC != 4'd0)
        iC <= iC - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_SHOW_F;
      cnt    <= '0;
      switch <= SEL_FREQ;
    end else if (!auto_en) begin
      state  <= sel_manual ? S_SHOW_C : S_SHOW_F;
      cnt    <= '0;
      switch <= sel_manual;
    end else if (f_adj) begin
      state  <= S_HOLD_F;
      cnt    <= '0;
      switch <= SEL_FREQ;
    end else if (c_adj) begin
      state  <= S_HOLD_C;
      cnt    <= '0;
      switch <= SEL_CURR;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        S_SHOW_F: if (cnt == CW'(DWELL_CYCLES - 1)) begin
          state <= S_SHOW_C; cnt <= '0; switch <= SEL_CURR;
        end
        S_SHOW_C: if (cnt == CW'(DWELL_CYCLES - 1)) begin
          state <= S_SHOW_F; cnt <= '0; switch <= SEL_FREQ;
        end
        S_HOLD_F: if (cnt == CW'(HOLD_CYCLES - 1)) begin
          state <= S_SHOW_F; cnt <= '0; switch <= SEL_FREQ;
        end
        S_HOLD_C: if (cnt == CW'(HOLD_CYCLES - 1)) begin
          state <= S_SHOW_C; cnt <= '0; switch <= SEL_CURR;
        end
        default: begin
          state <= S_SHOW_F; cnt <= '0; switch <= SEL_FREQ;
        end
      endcase
    end
  end

endmodule
